// File: rtl/servo_debounce.sv
// Single-channel RC-servo driver with a debounced switch input.
//   A 28-bit frame counter sets the PWM period (FRAME_MAX+1 cycles). The
//   internal position moves toward DESIRED, and each frame the pulse width
//   is BASE_WIDTH + position. FLAG is high when the position equals DESIRED.
//   The switch path runs a 2-flop synchroniser, then a DB_DEPTH-deep
//   agreement filter sampled on COUNT[10] rising edges, then a rise strobe.
// Build option: define SERVO_SLEW_EN to ramp the position by STEP once per
//   COUNT[8] rising edge. Without it, the position tracks DESIRED every cycle.
// Ports:
//   CLK      system clock, rising edge
//   RST      asynchronous active-high reset
//   DESIRED  target position, in cycles above BASE_WIDTH
//   SW_IN    raw asynchronous switch
//   PWM      registered servo pulse
//   FLAG     registered "position == DESIRED"
//   COUNT    frame counter, exported for sharing
//   SW_OUT   debounced switch level
//   SW_RISE  one-cycle strobe on each SW_OUT 0->1 transition
module servo_debounce #(
  parameter int unsigned FRAME_MAX  = 2000000,
  parameter int unsigned BASE_WIDTH = 50000,
  parameter int unsigned INIT_POS   = 0,
  parameter int unsigned STEP       = 1,
  parameter int unsigned DB_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [19:0] DESIRED,
  input  logic        SW_IN,
  output logic        PWM,
  output logic        FLAG,
  output logic [27:0] COUNT,
  output logic        SW_OUT,
  output logic        SW_RISE
);

  localparam logic [27:0] FRAME_MAX_W  = 28'(FRAME_MAX);
  localparam logic [20:0] BASE_WIDTH_W = 21'(BASE_WIDTH);
  localparam logic [19:0] INIT_POS_W   = 20'(INIT_POS);

  logic [19:0]         pos;
  logic [19:0]         pos_nxt;
  logic [20:0]         width;
  logic                bit10_q;
  logic                db_tick;
  logic                sync1;
  logic                sync2;
  logic [DB_DEPTH-1:0] db_sr;
  logic                sw_out_q;

  // Frame counter. The >= compare also recovers if the counter ever
  // lands above FRAME_MAX.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) COUNT <= '0;
    else     COUNT <= (COUNT >= FRAME_MAX_W) ? '0 : COUNT + 28'd1;
  end

`ifdef SERVO_SLEW_EN
  localparam logic [19:0] STEP_W = 20'(STEP);

  logic        bit8_q;
  logic        slew_tick;
  logic [19:0] gap_up;
  logic [19:0] gap_dn;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) bit8_q <= 1'b0;
    else     bit8_q <= COUNT[8];
  end

  assign slew_tick = COUNT[8] & ~bit8_q;

  // The step is clamped to the remaining gap, so the position can never
  // overshoot DESIRED or wrap.
  always_comb begin
    gap_up  = DESIRED - pos;
    gap_dn  = pos - DESIRED;
    pos_nxt = pos;
    if (slew_tick) begin
      if (pos < DESIRED)
        pos_nxt = pos + ((gap_up < STEP_W) ? gap_up : STEP_W);
      else if (pos > DESIRED)
        pos_nxt = pos - ((gap_dn < STEP_W) ? gap_dn : STEP_W);
    end
  end
`else
  assign pos_nxt = DESIRED;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pos <= INIT_POS_W;
    else     pos <= pos_nxt;
  end

  // The pulse is registered, so PWM trails the compare by one cycle. It is
  // high while COUNT runs 0 .. width-1, which gives exactly 'width' cycles.
  assign width = BASE_WIDTH_W + {1'b0, pos};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PWM  <= 1'b0;
      FLAG <= 1'b0;
    end else begin
      PWM  <= (28'(width) > COUNT);
      FLAG <= (pos == DESIRED);
    end
  end

  // Switch path: two-flop synchroniser, then a slow sampler.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      bit10_q <= 1'b0;
    end else begin
      sync1   <= SW_IN;
      sync2   <= sync1;
      bit10_q <= COUNT[10];
    end
  end

  assign db_tick = COUNT[10] & ~bit10_q;

  // The output changes only once every bit in the window agrees.
  // Mixed windows hold the previous level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db_sr    <= '0;
      SW_OUT   <= 1'b0;
      sw_out_q <= 1'b0;
    end else begin
      if (db_tick) db_sr <= {db_sr[DB_DEPTH-2:0], sync2};
      if (db_sr == {DB_DEPTH{1'b1}})      SW_OUT <= 1'b1;
      else if (db_sr == {DB_DEPTH{1'b0}}) SW_OUT <= 1'b0;
      sw_out_q <= SW_OUT;
    end
  end

  assign SW_RISE = SW_OUT & ~sw_out_q;

endmodule

// File: tb/tb_servo_debounce.sv
module tb_servo_debounce;

  localparam int FRAME_MAX = 4095;
  localparam int PERIOD    = FRAME_MAX + 1;
  localparam int BASE      = 1000;
  localparam int STEP      = 2;
  localparam int DB_PER    = 2048;

  logic        CLK = 1'b0;
  logic        RST;
  logic [19:0] DESIRED;
  logic        SW_IN;
  logic        PWM;
  logic        FLAG;
  logic [27:0] COUNT;
  logic        SW_OUT;
  logic        SW_RISE;

  int checks   = 0;
  int failures = 0;
  int exp_w[$];

  servo_debounce #(
    .FRAME_MAX (FRAME_MAX),
    .BASE_WIDTH(BASE),
    .INIT_POS  (0),
    .STEP      (STEP),
    .DB_DEPTH  (4)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .DESIRED(DESIRED),
    .SW_IN  (SW_IN),
    .PWM    (PWM),
    .FLAG   (FLAG),
    .COUNT  (COUNT),
    .SW_OUT (SW_OUT),
    .SW_RISE(SW_RISE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_width(input string tag, input int w);
    int e;
    if (exp_w.size() == 0) e = -1;
    else                   e = exp_w.pop_front();
    check(tag, 32'(w), 32'(e));
  endtask

  // Called at a negedge. Returns at the first negedge where PWM is seen rising.
  task automatic wait_pwm_rise(output bit ok);
    logic prev;
    int   n;
    ok   = 1'b0;
    prev = PWM;
    n    = 0;
    while (!ok && n < 2 * PERIOD) begin
      @(negedge CLK);
      n++;
      if (PWM && !prev) ok = 1'b1;
      prev = PWM;
    end
  endtask

  // Called at a negedge where PWM is high. Returns at the first low sample.
  task automatic measure_high(output int w);
    w = 1;
    @(negedge CLK);
    while (PWM && w < PERIOD) begin
      w++;
      @(negedge CLK);
    end
  endtask

  // Called at a negedge. Counts cycles until FLAG is sampled high.
  task automatic wait_flag(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 8 * 512) begin
      @(negedge CLK);
      n++;
      if (FLAG) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int w;
    int per;
    int n;
    int hi_cnt;
    int rises;
    int lat;
    bit found;
    bit rise_first;

    RST     = 1'b1;
    DESIRED = 20'd0;
    SW_IN   = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_count",   32'(COUNT),   32'd0);
    check("rst_pwm",     32'(PWM),     32'd0);
    check("rst_flag",    32'(FLAG),    32'd0);
    check("rst_sw_out",  32'(SW_OUT),  32'd0);
    check("rst_sw_rise", 32'(SW_RISE), 32'd0);

    // First frame with DESIRED = 0
    exp_w.push_back(BASE);
    RST = 1'b0;
    @(negedge CLK);
    check("first_count", 32'(COUNT), 32'd1);
    check("first_pwm",   32'(PWM),   32'd1);
    check("first_flag",  32'(FLAG),  32'd1);
    measure_high(w);
    check_width("width_base", w);
    per = w + 1;
    @(negedge CLK);
    while (!PWM && per < 3 * PERIOD) begin
      per++;
      @(negedge CLK);
    end
    check("frame_period",   32'(per),   32'(PERIOD));
    check("count_at_rise",  32'(COUNT), 32'd1);

`ifdef SERVO_SLEW_EN
    // Ramp 0 -> 11 with STEP 2. The last step must clamp to 1.
    DESIRED = 20'd11;
    exp_w.push_back(BASE + 11);
    @(negedge CLK);
    check("slew_up_flag_low", 32'(FLAG), 32'd0);
    wait_flag(n, ok);
    check("slew_up_settled", 32'(ok), 32'd1);
    check("slew_up_time_ok", 32'((n >= 5 * 512) && (n <= 6 * 512 + 3)), 32'd1);
    wait_pwm_rise(ok);
    check("slew_up_rise", 32'(ok), 32'd1);
    measure_high(w);
    check_width("width_slew_up", w);

    // Ramp back down 11 -> 1.
    DESIRED = 20'd1;
    exp_w.push_back(BASE + 1);
    @(negedge CLK);
    check("slew_dn_flag_low", 32'(FLAG), 32'd0);
    wait_flag(n, ok);
    check("slew_dn_settled", 32'(ok), 32'd1);
    check("slew_dn_time_ok", 32'((n >= 4 * 512) && (n <= 5 * 512 + 3)), 32'd1);
    wait_pwm_rise(ok);
    check("slew_dn_rise", 32'(ok), 32'd1);
    measure_high(w);
    check_width("width_slew_dn", w);
`else
    // Direct load: position follows DESIRED the next cycle.
    DESIRED = 20'd3000;
    exp_w.push_back(BASE + 3000);
    @(negedge CLK);
    check("step_flag_low",  32'(FLAG), 32'd0);
    @(negedge CLK);
    check("step_flag_high", 32'(FLAG), 32'd1);
    wait_pwm_rise(ok);
    check("step_rise", 32'(ok), 32'd1);
    measure_high(w);
    check_width("width_step_big", w);

    DESIRED = 20'd5;
    exp_w.push_back(BASE + 5);
    wait_pwm_rise(ok);
    check("step2_rise", 32'(ok), 32'd1);
    measure_high(w);
    check_width("width_step_small", w);
    check("step2_flag", 32'(FLAG), 32'd1);
`endif

    // Debounce: chatter whose samples alternate, so no window ever agrees.
    hi_cnt = 0;
    rises  = 0;
    for (int i = 0; i < 5 * DB_PER; i++) begin
      @(negedge CLK);
      SW_IN = COUNT[11] ^ ((COUNT[9:0] < 10'd800) & COUNT[6]);
      if (SW_OUT)  hi_cnt++;
      if (SW_RISE) rises++;
    end
    check("db_bounce_out",  32'(hi_cnt), 32'd0);
    check("db_bounce_rise", 32'(rises),  32'd0);

    // Clean high level
    SW_IN      = 1'b1;
    rises      = 0;
    found      = 1'b0;
    lat        = 0;
    rise_first = 1'b0;
    for (int i = 1; i <= 6 * DB_PER; i++) begin
      @(negedge CLK);
      if (SW_RISE) rises++;
      if (SW_OUT && !found) begin
        found      = 1'b1;
        lat        = i;
        rise_first = SW_RISE;
      end
    end
    check("db_high_out",     32'(SW_OUT),     32'd1);
    check("db_rise_once",    32'(rises),      32'd1);
    check("db_rise_aligned", 32'(rise_first), 32'd1);
    check("db_latency_ok",   32'(found && (lat >= 2 * DB_PER) && (lat <= 4 * DB_PER + 4)), 32'd1);

    // Clean low level: the output falls with no rise strobe.
    SW_IN = 1'b0;
    rises = 0;
    for (int i = 0; i < 5 * DB_PER; i++) begin
      @(negedge CLK);
      if (SW_RISE) rises++;
    end
    check("db_low_out",     32'(SW_OUT), 32'd0);
    check("db_low_no_rise", 32'(rises),  32'd0);

    // Reset in the middle of a pulse
    n = 0;
    while (COUNT != 28'd1000 && n < 2 * PERIOD) begin
      @(negedge CLK);
      n++;
    end
    check("mid_count_found", 32'(COUNT), 32'd1000);
    check("mid_pwm_high",    32'(PWM),   32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_count", 32'(COUNT), 32'd0);
    check("mid_rst_pwm",   32'(PWM),   32'd0);
    check("mid_rst_flag",  32'(FLAG),  32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("restart_count", 32'(COUNT), 32'd1);
    check("restart_pwm",   32'(PWM),   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
